// File: rtl/vdecoder_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
package vdecoder_pkg;

  localparam int SYNC_LEN = 8;
  localparam int ERR_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CLEAR,
    DECODE,
    DRAIN,
    DONE
  } vseq_state_t;

endpackage

// File: rtl/vseq_fifo.sv
// Small synchronous 1-bit FIFO; a push on full succeeds only with a pop.
module vseq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic data,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vdecoder_seq.sv
// Frame sequencer: sync hunt, decoder control, error counting and
// buffered delivery of decoded bits.
module vdecoder_seq
  import vdecoder_pkg::*;
#(
  parameter int                  FRAME_LEN  = 64,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'hA7,
  parameter int                  HUNT_MAX   = 1024,
  parameter int                  ERR_LIMIT  = 4,
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_bit,
  output logic             dec_in,
  output logic             dec_clr,
  output logic             dec_en,
  input  logic             dec_valid,
  input  logic             dec_out,
  input  logic             dec_error,
  output logic             bit_valid,
  output logic             bit_data,
  input  logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic             aborted,
  output logic             overrun,
  output logic             sync_fail
);

  localparam int HW = $clog2(HUNT_MAX + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(ERR_LIMIT);
  localparam bit ABORT_ON =
    ERR_LIMIT != 0 && ERR_LIMIT < (1 << ERR_W);

  vseq_state_t         state;
  vseq_state_t         state_nx;
  logic [SYNC_LEN-1:0] sreg;
  logic [SYNC_LEN-1:0] sh;
  logic [HW-1:0]       hunt_cnt;
  logic [15:0]         bit_cnt;
  logic [15:0]         bit_inc;
  logic [ERR_W-1:0]    err_inc;
  logic                in_q;
  logic                match;
  logic                timeout;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                head;
  logic                hit_err;
  logic                frame_end;
  logic                abort_hit;
  logic                drop;

  assign dec_in    = in_q;
  assign busy      = state != IDLE;
  assign dec_clr   = state == CLEAR;
  assign dec_en    = state == DECODE;
  assign done      = state == DONE;
  assign bit_valid = !empty;
  assign bit_data  = head && !empty;

  always_comb begin
    sh        = {sreg[SYNC_LEN-2:0], in_q};
    match     = sh == SYNC_WORD &&
                hunt_cnt >= HW'(SYNC_LEN - 1);
    timeout   = hunt_cnt == HW'(HUNT_MAX);
    push      = dec_en && dec_valid;
    hit_err   = push && dec_error;
    bit_inc   = bit_cnt + 16'd1;
    err_inc   = err_count == ERR_MAX ?
                err_count : err_count + 1'b1;
    frame_end = push && bit_inc == 16'(FRAME_LEN);
    abort_hit = ABORT_ON && hit_err && err_inc == ERR_LIM;
    pop       = !empty && bit_ready;
    drop      = push && full && !pop;
    state_nx  = state;
    unique case (state)
      IDLE:    if (start) state_nx = HUNT;
      HUNT: begin
        // a match in the timeout cycle still wins
        if (match)        state_nx = CLEAR;
        else if (timeout) state_nx = DONE;
      end
      CLEAR:   state_nx = DECODE;
      DECODE:  if (frame_end || abort_hit) state_nx = DRAIN;
      DRAIN:   if (empty) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_q      <= 1'b0;
      sreg      <= '0;
      hunt_cnt  <= '0;
      bit_cnt   <= '0;
      err_count <= '0;
      aborted   <= 1'b0;
      overrun   <= 1'b0;
      sync_fail <= 1'b0;
    end else begin
      state <= state_nx;
      in_q  <= in_bit;
      unique case (1'b1)
        state == IDLE && start: begin
          sreg      <= '0;
          hunt_cnt  <= '0;
          bit_cnt   <= '0;
          err_count <= '0;
          aborted   <= 1'b0;
          overrun   <= 1'b0;
          sync_fail <= 1'b0;
        end
        state == HUNT: begin
          sreg     <= sh;
          hunt_cnt <= hunt_cnt + HW'(1);
          if (timeout && !match) sync_fail <= 1'b1;
        end
        push: begin
          bit_cnt <= bit_inc;
          if (hit_err)   err_count <= err_inc;
          if (abort_hit) aborted   <= 1'b1;
          if (drop)      overrun   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  vseq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .data (dec_out),
    .head (head),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_vdecoder_seq.sv
// Bench for vdecoder_seq: frame table, hand sequences and random frames
// against a cycle-schedule and queue reference model.
module tb_vdecoder_seq;

  localparam int FLEN  = 64;
  localparam int HMAX  = 16;
  localparam int ELIM  = 4;
  localparam int DEPTH = 4;
  localparam int SLEN  = 400;
  localparam int NEVER = 1 << 30;
  localparam logic [7:0] SYNC = 8'hA7;

  logic clock = 0;
  logic reset = 1;
  logic start = 0;
  logic in_bit = 0;
  logic dec_valid = 0;
  logic dec_out = 0;
  logic dec_error = 0;
  logic bit_ready = 0;
  logic dec_in, dec_clr, dec_en, bit_valid, bit_data;
  logic busy, done, aborted, overrun, sync_fail;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vdecoder_seq #(
    .FRAME_LEN (FLEN),
    .SYNC_WORD (SYNC),
    .HUNT_MAX  (HMAX),
    .ERR_LIMIT (ELIM),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_bit   (in_bit),
    .dec_in   (dec_in),
    .dec_clr  (dec_clr),
    .dec_en   (dec_en),
    .dec_valid(dec_valid),
    .dec_out  (dec_out),
    .dec_error(dec_error),
    .bit_valid(bit_valid),
    .bit_data (bit_data),
    .bit_ready(bit_ready),
    .busy     (busy),
    .done     (done),
    .err_count(err_count),
    .aborted  (aborted),
    .overrun  (overrun),
    .sync_fail(sync_fail)
  );

  typedef struct {
    int          pre;
    logic [63:0] emask;
    int          rmode;
    int          restart;
    int          exp_bits;
    int          exp_err;
    logic        exp_ab;
    logic        exp_ov;
    logic        exp_sf;
  } vec_t;

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chkn(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_dec_in"}, dec_in, 1'b0);
    chk1({tag, "_dec_clr"}, dec_clr, 1'b0);
    chk1({tag, "_dec_en"}, dec_en, 1'b0);
    chk1({tag, "_bit_valid"}, bit_valid, 1'b0);
    chk1({tag, "_bit_data"}, bit_data, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chkn({tag, "_err_count"}, int'(err_count), 0);
    chk1({tag, "_aborted"}, aborted, 1'b0);
    chk1({tag, "_overrun"}, overrun, 1'b0);
    chk1({tag, "_sync_fail"}, sync_fail, 1'b0);
  endtask

  // pre<0: all-zero stream (no sync). noise: random prefix bits.
  // rmode 0: ready always, 1: ready only 6 cycles after decode ends,
  // 2: random. rst_at>0: reset after that many decoder bits.
  task automatic run_frame(input int pre, input bit noise,
                           input logic [63:0] emask, input int rmode,
                           input int vpct, input int restart,
                           input int rst_at, output int ndel);
    logic s[SLEN];
    logic q[$];
    logic [7:0] w;
    logic [7:0] sw;
    int ksync, dec_end, done_cyc, natt, errs, c;
    bit ov, ab, rdy, v, in_win, full, pop, stopped;
    sw = SYNC;
    for (int j = 0; j < SLEN; j++) begin
      if (pre < 0) s[j] = 1'b0;
      else if (j < pre) s[j] = noise ? 1'($urandom_range(1)) : 1'b0;
      else if (j < pre + 8) s[j] = sw[7 - (j - pre)];
      else s[j] = 1'($urandom_range(1));
    end
    // sample k of the hunt (k>=1) is stream bit k-1
    ksync = 0;
    for (int k = 8; k <= HMAX + 1 && ksync == 0; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w = {w[6:0], s[k - 8 + j]};
      if (w == SYNC) ksync = k;
    end
    dec_end  = ksync != 0 ? NEVER : 0;
    done_cyc = ksync != 0 ? NEVER : HMAX + 2;
    ndel = 0; natt = 0; errs = 0;
    ov = 0; ab = 0; stopped = 0;
    start = 1; in_bit = s[0];
    dec_valid = 0; bit_ready = 1;
    for (c = 1; c <= done_cyc + 1 && c < 3000; c++) begin
      step();
      if (ksync != 0 && c > dec_end && done_cyc == NEVER &&
          q.size() == 0)
        done_cyc = c + 1;
      in_win = ksync != 0 && c >= ksync + 2 && c <= dec_end;
      chk1("busy", busy, c <= done_cyc);
      chk1("dec_clr", dec_clr, ksync != 0 && c == ksync + 1);
      chk1("dec_en", dec_en, in_win);
      chk1("done", done, c == done_cyc);
      chk1("dec_in", dec_in, s[c - 1]);
      chk1("bit_valid", bit_valid, q.size() != 0);
      if (q.size() != 0) chk1("bit_data", bit_data, q[0]);
      start = ksync != 0 && restart >= 0 &&
              c == ksync + 2 + restart;
      in_bit = c < SLEN ? s[c] : 1'b0;
      case (rmode)
        0: rdy = 1;
        1: rdy = dec_end != NEVER && c > dec_end + 5;
        default: rdy = 1'($urandom_range(1));
      endcase
      bit_ready = rdy;
      v = 0;
      if (in_win) begin
        v = $urandom_range(99) < vpct;
        dec_valid = v;
        dec_out = 1'($urandom_range(1));
        dec_error = v ? emask[natt] : 1'($urandom_range(1));
      end else begin
        dec_valid = 1'($urandom_range(1));
        dec_out = 1'($urandom_range(1));
        dec_error = 1'($urandom_range(1));
      end
      if (bit_valid && bit_ready) ndel++;
      full = q.size() == DEPTH;
      pop = q.size() != 0 && rdy;
      if (pop) void'(q.pop_front());
      if (in_win && v) begin
        natt++;
        if (!full || pop) q.push_back(dec_out);
        else ov = 1;
        if (emask[natt - 1] && errs < 255) errs++;
        if (emask[natt - 1] && errs == ELIM) ab = 1;
        if (natt == FLEN || (emask[natt - 1] && errs == ELIM))
          dec_end = c;
        if (rst_at > 0 && natt == rst_at) stopped = 1;
      end
      if (stopped) break;
    end
    chk1("frame_bound", c < 3000, 1'b1);
    if (stopped) begin
      #2 reset = 1;
      #1 chk_zero("midreset");
      #2 reset = 0;
      start = 0;
      dec_valid = 0;
      step();
      chk1("post_reset_busy", busy, 1'b0);
      chk1("post_reset_fifo", bit_valid, 1'b0);
    end else begin
      chkn("err_count", int'(err_count), errs);
      chk1("aborted", aborted, ab);
      chk1("overrun", overrun, ov);
      chk1("sync_fail", sync_fail, ksync == 0);
    end
  endtask

  vec_t tab[8];
  int nd;
  logic [63:0] em;

  initial begin
    tab[0] = '{0,  64'h0,   0, -1, 64, 0, 0, 0, 0};
    tab[1] = '{-1, 64'h0,   0, -1, 0,  0, 0, 0, 1};
    tab[2] = '{3,  64'h944, 0, -1, 12, 4, 1, 0, 0};
    tab[3] = '{2,  64'h0,   1, -1, 4,  0, 0, 1, 0};
    tab[4] = '{5,  64'h0,   0, 10, 64, 0, 0, 0, 0};
    tab[5] = '{9,  64'h0,   0, -1, 64, 0, 0, 0, 0};
    tab[6] = '{10, 64'h0,   0, -1, 0,  0, 0, 0, 1};
    tab[7] = '{1,  64'h8000_0000_0000_0001, 0, -1, 64, 2, 0, 0, 0};

    reset = 1;
    step();
    step();
    chk_zero("reset");
    #4 reset = 0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_frame(tab[i].pre, 0, tab[i].emask, tab[i].rmode, 100,
                tab[i].restart, 0, nd);
      chkn($sformatf("tab%0d_bits", i), nd, tab[i].exp_bits);
      chkn($sformatf("tab%0d_err", i), int'(err_count),
           tab[i].exp_err);
      chk1($sformatf("tab%0d_ab", i), aborted, tab[i].exp_ab);
      chk1($sformatf("tab%0d_ov", i), overrun, tab[i].exp_ov);
      chk1($sformatf("tab%0d_sf", i), sync_fail, tab[i].exp_sf);
    end

    run_frame(0, 0, 64'h0, 0, 100, -1, 20, nd);
    run_frame(4, 0, 64'h0, 0, 100, -1, 0, nd);
    chkn("after_reset_bits", nd, 64);
    chk1("after_reset_clean", aborted | overrun | sync_fail, 1'b0);

    for (int r = 0; r < 10; r++) begin
      em = '0;
      for (int b = 0; b < 64; b++)
        em[b] = $urandom_range(39) == 0;
      run_frame(int'($urandom_range(6)), 1, em, 2, 70, -1, 0, nd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vdecoder_seq.md
# vdecoder_seq

Frame sequencer for the PRML Viterbi decoder datapath. It hunts the raw channel bit stream for a sync word, clears and enables the decoder for one frame of payload, and counts decoder error flags. Decoded bits go to downstream logic through a valid/ready port backed by a small FIFO. It sits between the channel sampler and the decoder and owns every decoder control line.

## Interface
- `FRAME_LEN`, 64: decoded bits per frame (1..65535).
- `SYNC_WORD`, 8'hA7: sync pattern. MSB is the oldest sample.
- `HUNT_MAX`, 1024: cycles allowed in HUNT before failure (≥ 8).
- `ERR_LIMIT`, 4: error count that aborts the frame. 0 disables abort.
- `FIFO_DEPTH`, 4: output FIFO entries. Power of two, ≥ 2.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  frame request. Sampled only in IDLE.
- `in_bit`  in  1  raw channel sample, one per clock.
- `dec_in`  out  1  `in_bit` delayed one register, fed to the decoder.
- `dec_clr`  out  1  one-cycle pulse that resets decoder trellis state and sample pair.
- `dec_en`  out  1  decoder enable. High only in DECODE.
- `dec_valid`  in  1  decoder produced a bit this cycle.
- `dec_out`  in  1  decoded bit, qualified by `dec_valid`.
- `dec_error`  in  1  illegal trellis transition, qualified by `dec_valid`.
- `bit_valid`  out  1  FIFO head valid.
- `bit_data`  out  1  FIFO head bit.
- `bit_ready`  in  1  downstream accept.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle end-of-frame pulse.
- `err_count`  out  8  saturating error count for the current or last frame.
- `aborted`, `overrun`, `sync_fail`  out  1 each  sticky status for the last frame.

## Operation
- **States:** IDLE, HUNT, CLEAR, DECODE, DRAIN, DONE.
- **IDLE → HUNT** on `start`. On this transition, clear all status outputs, the hunt counter, the bit counter and the 8-bit sync shift register. `start` in any other state is ignored.
- **HUNT:**
  - Shift `dec_in` into the shift register every cycle.
  - Go to CLEAR in the cycle after the register equals `SYNC_WORD` with at least 8 samples shifted since entry.
  - If the hunt counter reaches `HUNT_MAX` with no match, set `sync_fail` and go to DONE. A match in the same cycle wins over the timeout.
- **CLEAR:** lasts exactly one cycle with `dec_clr`=1, then go to DECODE. The first `dec_in` sample seen in DECODE is the first payload sample after the sync word.
- **DECODE:** `dec_en`=1.
  - Each `dec_valid` pushes `dec_out` into the FIFO and increments the 16-bit bit counter.
  - `dec_valid` with `dec_error` increments `err_count`, saturating at 255.
  - Leave for DRAIN when the bit counter reaches `FRAME_LEN`.
  - Also leave for DRAIN, with `aborted` set, when `ERR_LIMIT`≠0 and `err_count` reaches `ERR_LIMIT`. The bit that caused the abort is still pushed.
- **FIFO full on a push:** drop the bit and set `overrun`. The decoder is never stalled. A push and a pop in the same cycle on a full FIFO succeeds.
- **DRAIN:** `dec_en`=0. Stay until the FIFO is empty, then go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Status hold:** `err_count`, `aborted`, `overrun` and `sync_fail` hold until the next accepted `start`.
- **Reset:** all registers go to zero, the state to IDLE and the FIFO to empty. Reset mid-frame discards FIFO contents; no `done` pulse is produced.

## Timing
- **Reset values:** every output is 0, including `dec_in`.
- **`dec_in`:** lags `in_bit` by 1 cycle.
- **Start latency:** `start` at cycle t gives `busy`=1 at t+1 (state HUNT).
- **Sync match:** if the last sync sample appears on `dec_in` at cycle t, `dec_clr`=1 at t+1 and `dec_en`=1 from t+2.
- **FIFO:** `bit_valid` rises the cycle after the push; transfer happens when `bit_valid` && `bit_ready`.
- **`done` latency:** `done` asserts the cycle after DRAIN observes an empty FIFO. Minimum DRAIN→DONE is 1 cycle.
- **Controls:** `dec_clr`, `dec_en`, `busy` and `done` are registered decodes of state with no combinational path from inputs.

## Structure
- **`vdecoder_pkg`:** state enum `vseq_state_t`; constants `SYNC_LEN`=8 and `ERR_W`=8.
- **`vseq_fifo`:** synchronous FIFO, parameterised by depth, with push/pop/full/empty. This is the only submodule; the FSM, counters and sync shifter stay in `vdecoder_seq`.

## Test plan
- **Clean frame:** `SYNC_WORD` 8'hA7, then decoder model returns 64 bits with no error and `bit_ready`=1 → 64 bits out in order, `done` once, `err_count`=0, all flags 0.
- **Sync timeout:** `HUNT_MAX`=16, stream of all zeros → `sync_fail`=1, `done` at cycle 18 after `start`, `dec_clr` never pulses.
- **Error abort:** `ERR_LIMIT`=4, `dec_error` on bits 3, 7, 9, 12 → `aborted`=1, exactly 12 bits delivered, `err_count`=4.
- **Backpressure:** `bit_ready`=0 throughout DECODE with `FIFO_DEPTH`=4 → first 4 bits retained, `overrun`=1, DRAIN holds until `bit_ready` rises, then 4 bits out and `done`.
- **Reset mid-frame:** reset after 20 payload bits → all outputs 0 and FIFO empty; a following `start` with a clean frame completes normally.
- **Start ignored while busy:** `start` pulsed during DECODE → no effect on counters or state; frame completes with 64 bits.
